// File: rtl/dmem_bus_ctrl.sv
// MEM-stage data bus controller: sequences loads/stores onto an OBI-style
// req/gnt/rvalid bus, stalls the pipeline, formats sub-word data, detects halt/timeout.
module dmem_bus_ctrl #(
    parameter logic [31:0] HALT_LO = 32'h0002_0000,
    parameter logic [31:0] HALT_HI = 32'h0002_0FFF,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_mem_mem2reg,
    input  logic        i_mem_wmem,
    input  logic        i_mem_lsb,
    input  logic        i_mem_lsh,
    input  logic        i_mem_loadsignext,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    output logic        data_req_o,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    output logic        o_stall,
    output logic        o_load_valid,
    output logic [31:0] o_load_data,
    output logic        o_misaligned,
    output logic        o_bus_err,
    output logic        o_stop_core
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HALT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             ld_q, lsb_q, lsh_q, sext_q;
    logic [1:0]       off_q;
    logic             stop_q, err_q;

    logic        acc, is_store, misaligned, halt_st, issue, timeout_hit;
    logic        req_c, mis_c, lv_c, set_stop, set_err, cnt_clr, cnt_inc, latch;
    logic [3:0]  be_c;
    logic [31:0] wd_c, fmt_c;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Access decode; a load wins when both load and store are flagged
    assign acc         = i_mem_mem2reg | i_mem_wmem;
    assign is_store    = i_mem_wmem & ~i_mem_mem2reg;
    assign misaligned  = i_mem_lsb ? 1'b0 :
                         i_mem_lsh ? i_mem_addr[0] : (i_mem_addr[1:0] != 2'b00);
    assign halt_st     = is_store & (i_mem_addr > HALT_LO) & (i_mem_addr < HALT_HI)
                         & (i_mem_wdata != 32'h0);
    assign issue       = acc & ~misaligned & ~halt_st;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        be_c = 4'b1111;
        wd_c = i_mem_wdata;
        if (i_mem_lsb) begin
            be_c = 4'b0001 << i_mem_addr[1:0];
            wd_c = {4{i_mem_wdata[7:0]}};
        end else if (i_mem_lsh) begin
            be_c = i_mem_addr[1] ? 4'b1100 : 4'b0011;
            wd_c = {2{i_mem_wdata[15:0]}};
        end
    end

    // Load lane select and extension from the attributes captured at grant
    always_comb begin
        case (off_q)
            2'd0:    lane_b = data_rdata_i[7:0];
            2'd1:    lane_b = data_rdata_i[15:8];
            2'd2:    lane_b = data_rdata_i[23:16];
            default: lane_b = data_rdata_i[31:24];
        endcase
        lane_h = off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
        if (lsb_q)      fmt_c = {{24{sext_q & lane_b[7]}}, lane_b};
        else if (lsh_q) fmt_c = {{16{sext_q & lane_h[15]}}, lane_h};
        else            fmt_c = data_rdata_i;
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        req_c    = 1'b0;
        o_stall  = 1'b0;
        mis_c    = 1'b0;
        lv_c     = 1'b0;
        set_stop = 1'b0;
        set_err  = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        latch    = 1'b0;
        case (state_q)
            IDLE: begin
                mis_c   = acc & misaligned;
                o_stall = acc & ~misaligned;
                if (acc & ~misaligned & halt_st) begin
                    set_stop = 1'b1;
                    state_d  = HALT;
                end else if (issue) begin
                    req_c   = 1'b1;
                    cnt_clr = 1'b1;
                    latch   = data_gnt_i;
                    state_d = data_gnt_i ? WAIT : REQ;
                end
            end
            REQ: begin
                req_c   = 1'b1;
                o_stall = 1'b1;
                cnt_inc = 1'b1;
                if (timeout_hit) begin
                    set_err  = 1'b1;
                    set_stop = 1'b1;
                    state_d  = HALT;
                end else if (data_gnt_i) begin
                    latch   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                o_stall = ~data_rvalid_i;
                cnt_inc = 1'b1;
                if (data_rvalid_i) begin
                    lv_c    = ld_q;
                    state_d = IDLE;
                end
                // A response in the timeout cycle still completes, but the halt takes priority
                if (timeout_hit) begin
                    set_err  = 1'b1;
                    set_stop = 1'b1;
                    state_d  = HALT;
                end
            end
            HALT: o_stall = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            cnt_q  <= '0;
            ld_q   <= 1'b0;
            lsb_q  <= 1'b0;
            lsh_q  <= 1'b0;
            sext_q <= 1'b0;
            off_q  <= 2'b00;
            stop_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (cnt_clr)      cnt_q <= '0;
            else if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
            if (latch) begin
                ld_q   <= i_mem_mem2reg;
                lsb_q  <= i_mem_lsb;
                lsh_q  <= i_mem_lsh;
                sext_q <= i_mem_loadsignext;
                off_q  <= i_mem_addr[1:0];
            end
            if (set_stop) stop_q <= 1'b1;
            if (set_err)  err_q  <= 1'b1;
        end
    end

    // Bus fields are only driven while requesting; reset drops the request immediately
    assign data_req_o   = req_c & i_resetn;
    assign data_addr_o  = data_req_o ? {i_mem_addr[31:2], 2'b00} : 32'h0;
    assign data_we_o    = data_req_o & is_store;
    assign data_be_o    = data_req_o ? be_c : 4'b0000;
    assign data_wdata_o = (data_req_o & is_store) ? wd_c : 32'h0;
    assign o_misaligned = mis_c & i_resetn;
    assign o_load_valid = lv_c;
    assign o_load_data  = lv_c ? fmt_c : 32'h0;
    assign o_bus_err    = err_q;
    assign o_stop_core  = stop_q;
endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Self-checking bench for dmem_bus_ctrl: per-feature tasks plus a load-data scoreboard.
module tb_dmem_bus_ctrl;
    localparam int unsigned TB_TIMEOUT = 6;

    logic        clk, rst_n;
    logic        mem2reg, wmem, lsb, lsh, sext;
    logic [31:0] mem_addr, mem_wdata;
    logic        req, we_o, gnt, rvalid;
    logic [31:0] addr_o, wd_o, rdata;
    logic [3:0]  be_o;
    logic        stall, lv, mis, berr, stop;
    logic [31:0] ld_data;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    dmem_bus_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
        .i_clk(clk), .i_resetn(rst_n),
        .i_mem_mem2reg(mem2reg), .i_mem_wmem(wmem), .i_mem_lsb(lsb), .i_mem_lsh(lsh),
        .i_mem_loadsignext(sext), .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata),
        .data_req_o(req), .data_addr_o(addr_o), .data_we_o(we_o), .data_be_o(be_o),
        .data_wdata_o(wd_o), .data_gnt_i(gnt), .data_rvalid_i(rvalid), .data_rdata_i(rdata),
        .o_stall(stall), .o_load_valid(lv), .o_load_data(ld_data), .o_misaligned(mis),
        .o_bus_err(berr), .o_stop_core(stop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every load result the DUT produces must match the oldest expected value
    always @(negedge clk) begin
        if (rst_n && lv) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: load_data=%h, no load expected", ld_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (ld_data !== e) begin
                    errors++;
                    $display("FAIL sb_load_data: got %h expected %h", ld_data, e);
                end
            end
        end
    end

    task automatic clear_inputs();
        mem2reg = 0; wmem = 0; lsb = 0; lsh = 0; sext = 0;
        mem_addr = 0; mem_wdata = 0; gnt = 0; rvalid = 0; rdata = 0;
    endtask

    task automatic idle(input int n);
        clear_inputs();
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    // Drives one access and plays bus slave; returns what was observed (called at posedge+1)
    task automatic run_access(input logic ld, input logic wm, input logic b, input logic h,
                              input logic sx, input logic [31:0] a, input logic [31:0] wdat,
                              input int gnt_dly, input int rv_dly, input logic dual,
                              input logic [31:0] rdat,
                              output int stalls, output int cycles, output logic got_req,
                              output logic [3:0] be, output logic [31:0] wd, output logic we,
                              output logic [31:0] ad, output logic got_lv, output logic done);
        int cnt;
        logic granted, fin;
        mem2reg = ld; wmem = wm; lsb = b; lsh = h; sext = sx; mem_addr = a; mem_wdata = wdat;
        stalls = 0; cycles = 0; got_req = 0; be = 0; wd = 0; we = 0; ad = 0; got_lv = 0;
        done = 0; cnt = 0; granted = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (!granted) begin
                gnt    = (cnt == gnt_dly);
                rvalid = gnt & dual;
                rdata  = dual ? 32'hBAD0_BAD0 : 32'h0;
            end else begin
                gnt    = 0;
                rvalid = (cnt == rv_dly);
                rdata  = rvalid ? rdat : 32'h0;
            end
            @(negedge clk);
            cycles++;
            if (stall) stalls++;
            if (req) begin got_req = 1; be = be_o; wd = wd_o; we = we_o; ad = addr_o; end
            if (lv) got_lv = 1;
            fin = granted && rvalid;
            if (!granted && gnt) begin granted = 1; cnt = 0; end
            else cnt++;
            @(posedge clk); #1;
            done = fin;
        end
        gnt = 0; rvalid = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        #3;
        checks++; if (req !== 1'b0)   begin errors++; $display("FAIL rst_req: got %b expected 0", req); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", stall); end
        checks++; if (berr !== 1'b0)  begin errors++; $display("FAIL rst_berr: got %b expected 0", berr); end
        checks++; if (stop !== 1'b0)  begin errors++; $display("FAIL rst_stop: got %b expected 0", stop); end
        checks++; if (lv !== 1'b0)    begin errors++; $display("FAIL rst_lv: got %b expected 0", lv); end
        mem2reg = 1; mem_addr = 32'h100;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_stall_acc: got %b expected 1", stall); end
        checks++; if (req !== 1'b0)   begin errors++; $display("FAIL rst_req_acc: got %b expected 0", req); end
        clear_inputs();
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_word_load();
        int st, cy; logic gr, we, gl, dn; logic [3:0] be; logic [31:0] wd, ad;
        exp_q.push_back(32'hDEAD_BEEF);
        run_access(1, 0, 0, 0, 0, 32'h100, 0, 0, 0, 0, 32'hDEAD_BEEF, st, cy, gr, be, wd, we, ad, gl, dn);
        checks++; if (st !== 1)        begin errors++; $display("FAIL wl_stalls: got %0d expected 1", st); end
        checks++; if (cy !== 2)        begin errors++; $display("FAIL wl_cycles: got %0d expected 2", cy); end
        checks++; if (be !== 4'hF)     begin errors++; $display("FAIL wl_be: got %b expected 1111", be); end
        checks++; if (we !== 1'b0)     begin errors++; $display("FAIL wl_we: got %b expected 0", we); end
        checks++; if (ad !== 32'h100)  begin errors++; $display("FAIL wl_addr: got %h expected 00000100", ad); end
        checks++; if (gl !== 1'b1)     begin errors++; $display("FAIL wl_valid: got %b expected 1", gl); end
        idle(1);
    endtask

    task automatic test_subword_load();
        int st, cy; logic gr, we, gl, dn; logic [3:0] be; logic [31:0] wd, ad;
        exp_q.push_back(32'hFFFF_FF80);
        run_access(1, 0, 1, 0, 1, 32'h103, 0, 0, 0, 0, 32'h8011_2233, st, cy, gr, be, wd, we, ad, gl, dn);
        checks++; if (be !== 4'b1000)  begin errors++; $display("FAIL lb_be: got %b expected 1000", be); end
        checks++; if (ad !== 32'h100)  begin errors++; $display("FAIL lb_addr: got %h expected 00000100", ad); end
        exp_q.push_back(32'h0000_0080);
        run_access(1, 0, 1, 0, 0, 32'h103, 0, 0, 0, 0, 32'h8011_2233, st, cy, gr, be, wd, we, ad, gl, dn);
        checks++; if (gl !== 1'b1)     begin errors++; $display("FAIL lbu_valid: got %b expected 1", gl); end
        exp_q.push_back(32'h0000_0022);
        run_access(1, 0, 1, 0, 1, 32'h101, 0, 0, 1, 0, 32'h8011_2233, st, cy, gr, be, wd, we, ad, gl, dn);
        checks++; if (be !== 4'b0010)  begin errors++; $display("FAIL lb1_be: got %b expected 0010", be); end
        exp_q.push_back(32'hFFFF_8011);
        run_access(1, 0, 0, 1, 1, 32'h102, 0, 0, 0, 0, 32'h8011_2233, st, cy, gr, be, wd, we, ad, gl, dn);
        checks++; if (be !== 4'b1100)  begin errors++; $display("FAIL lh_be: got %b expected 1100", be); end
        exp_q.push_back(32'h0000_2233);
        run_access(1, 0, 0, 1, 0, 32'h100, 0, 0, 0, 0, 32'h8011_2233, st, cy, gr, be, wd, we, ad, gl, dn);
        checks++; if (be !== 4'b0011)  begin errors++; $display("FAIL lhu_be: got %b expected 0011", be); end
        idle(1);
    endtask

    task automatic test_store();
        int st, cy; logic gr, we, gl, dn; logic [3:0] be; logic [31:0] wd, ad;
        run_access(0, 1, 0, 1, 0, 32'h202, 32'h0000_ABCD, 3, 0, 0, 0, st, cy, gr, be, wd, we, ad, gl, dn);
        checks++; if (be !== 4'b1100)       begin errors++; $display("FAIL sh_be: got %b expected 1100", be); end
        checks++; if (wd !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata: got %h expected abcdabcd", wd); end
        checks++; if (we !== 1'b1)          begin errors++; $display("FAIL sh_we: got %b expected 1", we); end
        checks++; if (st !== 4)             begin errors++; $display("FAIL sh_stalls: got %0d expected 4", st); end
        checks++; if (cy !== 5)             begin errors++; $display("FAIL sh_cycles: got %0d expected 5", cy); end
        checks++; if (gl !== 1'b0)          begin errors++; $display("FAIL sh_no_lv: got %b expected 0", gl); end
        run_access(0, 1, 1, 0, 0, 32'h201, 32'h0000_005A, 0, 2, 0, 0, st, cy, gr, be, wd, we, ad, gl, dn);
        checks++; if (be !== 4'b0010)       begin errors++; $display("FAIL sb_be: got %b expected 0010", be); end
        checks++; if (wd !== 32'h5A5A_5A5A) begin errors++; $display("FAIL sb_wdata: got %h expected 5a5a5a5a", wd); end
        checks++; if (st !== 3)             begin errors++; $display("FAIL sb_stalls: got %0d expected 3", st); end
        idle(1);
    endtask

    task automatic test_gnt_rvalid_same();
        int st, cy; logic gr, we, gl, dn; logic [3:0] be; logic [31:0] wd, ad;
        exp_q.push_back(32'h1234_5678);
        run_access(1, 0, 0, 0, 0, 32'h400, 0, 1, 0, 1, 32'h1234_5678, st, cy, gr, be, wd, we, ad, gl, dn);
        checks++; if (cy !== 3) begin errors++; $display("FAIL dual_cycles: got %0d expected 3", cy); end
        checks++; if (st !== 2) begin errors++; $display("FAIL dual_stalls: got %0d expected 2", st); end
        idle(1);
    endtask

    task automatic test_back_to_back();
        int st, cy; logic gr, we, gl, dn; logic [3:0] be; logic [31:0] wd, ad;
        exp_q.push_back(32'hA5A5_0001);
        run_access(1, 0, 0, 0, 0, 32'h500, 0, 0, 0, 0, 32'hA5A5_0001, st, cy, gr, be, wd, we, ad, gl, dn);
        run_access(0, 1, 0, 0, 0, 32'h504, 32'h7777_8888, 0, 0, 0, 0, st, cy, gr, be, wd, we, ad, gl, dn);
        checks++; if (cy !== 2)             begin errors++; $display("FAIL b2b_st_cycles: got %0d expected 2", cy); end
        checks++; if (wd !== 32'h7777_8888) begin errors++; $display("FAIL b2b_wdata: got %h expected 77778888", wd); end
        exp_q.push_back(32'h5A5A_0002);
        run_access(1, 0, 0, 0, 0, 32'h508, 0, 0, 0, 0, 32'h5A5A_0002, st, cy, gr, be, wd, we, ad, gl, dn);
        checks++; if (cy !== 2)             begin errors++; $display("FAIL b2b_ld_cycles: got %0d expected 2", cy); end
        checks++; if (ad !== 32'h508)       begin errors++; $display("FAIL b2b_addr: got %h expected 00000508", ad); end
        idle(1);
    endtask

    task automatic test_misaligned();
        mem2reg = 1; mem_addr = 32'h101;
        @(negedge clk);
        checks++; if (mis !== 1'b1)   begin errors++; $display("FAIL mis_pulse: got %b expected 1", mis); end
        checks++; if (req !== 1'b0)   begin errors++; $display("FAIL mis_req: got %b expected 0", req); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mis_stall: got %b expected 0", stall); end
        @(posedge clk); #1;
        clear_inputs();
        wmem = 1; lsh = 1; mem_addr = 32'h203; mem_wdata = 32'h1;
        @(negedge clk);
        checks++; if (mis !== 1'b1)   begin errors++; $display("FAIL mis_half: got %b expected 1", mis); end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        checks++; if (mis !== 1'b0)   begin errors++; $display("FAIL mis_clear: got %b expected 0", mis); end
        @(posedge clk); #1;
    endtask

    task automatic test_halt();
        int st, cy; logic gr, we, gl, dn; logic [3:0] be; logic [31:0] wd, ad;
        wmem = 1; mem_addr = 32'h0002_0010; mem_wdata = 32'h1;
        @(negedge clk);
        checks++; if (req !== 1'b0)   begin errors++; $display("FAIL halt_req: got %b expected 0", req); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL halt_stall0: got %b expected 1", stall); end
        checks++; if (stop !== 1'b0)  begin errors++; $display("FAIL halt_stop_early: got %b expected 0", stop); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (stop !== 1'b1)  begin errors++; $display("FAIL halt_stop: got %b expected 1", stop); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL halt_stall1: got %b expected 1", stall); end
        checks++; if (berr !== 1'b0)  begin errors++; $display("FAIL halt_berr: got %b expected 0", berr); end
        @(posedge clk); #1;
        do_reset();
        run_access(0, 1, 0, 0, 0, 32'h0002_0010, 32'h0, 0, 0, 0, 0, st, cy, gr, be, wd, we, ad, gl, dn);
        checks++; if (gr !== 1'b1)    begin errors++; $display("FAIL halt_w0_req: got %b expected 1", gr); end
        run_access(0, 1, 0, 0, 0, 32'h0002_0000, 32'h1, 0, 0, 0, 0, st, cy, gr, be, wd, we, ad, gl, dn);
        checks++; if (gr !== 1'b1)    begin errors++; $display("FAIL halt_lo_req: got %b expected 1", gr); end
        run_access(0, 1, 1, 0, 0, 32'h0002_0FFF, 32'h1, 0, 0, 0, 0, st, cy, gr, be, wd, we, ad, gl, dn);
        checks++; if (gr !== 1'b1)    begin errors++; $display("FAIL halt_hi_req: got %b expected 1", gr); end
        idle(1);
        checks++; if (stop !== 1'b0)  begin errors++; $display("FAIL halt_bounds_stop: got %b expected 0", stop); end
    endtask

    task automatic test_timeout();
        mem2reg = 1; mem_addr = 32'h600; gnt = 1;
        @(posedge clk); #1;
        gnt = 0;
        for (int k = 1; k <= int'(TB_TIMEOUT); k++) begin
            @(negedge clk);
            if (k == int'(TB_TIMEOUT)) begin
                checks++; if (berr !== 1'b0)  begin errors++; $display("FAIL to_early: got %b expected 0", berr); end
                checks++; if (stall !== 1'b1) begin errors++; $display("FAIL to_wait_stall: got %b expected 1", stall); end
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if (berr !== 1'b1)  begin errors++; $display("FAIL to_berr: got %b expected 1", berr); end
        checks++; if (stop !== 1'b1)  begin errors++; $display("FAIL to_stop: got %b expected 1", stop); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL to_halt_stall: got %b expected 1", stall); end
        checks++; if (req !== 1'b0)   begin errors++; $display("FAIL to_req: got %b expected 0", req); end
        #2;
        rst_n = 0;
        #1;
        checks++; if (berr !== 1'b0)  begin errors++; $display("FAIL to_rst_berr: got %b expected 0", berr); end
        checks++; if (stop !== 1'b0)  begin errors++; $display("FAIL to_rst_stop: got %b expected 0", stop); end
        clear_inputs();
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL to_rst_idle: got %b expected 0", stall); end
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int st, cy; logic gr, we, gl, dn; logic [3:0] be; logic [31:0] wd, ad;
        mem2reg = 1; mem_addr = 32'h700;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL rm_req: got %b expected 1", req); end
        #2;
        rst_n = 0;
        #1;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL rm_req_drop: got %b expected 0", req); end
        clear_inputs();
        @(posedge clk); #1;
        rst_n = 1;
        exp_q.push_back(32'h0BAD_F00D);
        run_access(1, 0, 0, 0, 0, 32'h704, 0, 0, 0, 0, 32'h0BAD_F00D, st, cy, gr, be, wd, we, ad, gl, dn);
        checks++; if (cy !== 2) begin errors++; $display("FAIL rm_idle_cycles: got %0d expected 2", cy); end
        idle(1);
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_subword_load();
        test_store();
        test_gnt_rvalid_same();
        test_back_to_back();
        test_misaligned();
        test_halt();
        test_timeout();
        test_reset_mid();
        idle(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_bus_ctrl.md
# dmem_bus_ctrl

Data-memory bus controller for the MEM stage. It takes the load/store control and data registered by the EXE/MEM pipeline register and sequences each access onto an OBI-style request/grant/rvalid data bus. It stalls the pipeline until each access completes, and formats byte and halfword loads and stores. It also detects the core-stop store to the halt MMIO window and the bus-timeout condition.

## Interface
- HALT_LO, 32'h0002_0000, lower bound of halt window (exclusive)
- HALT_HI, 32'h0002_0FFF, upper bound of halt window (exclusive)
- TIMEOUT, 255, max cycles an access may remain outstanding (1..255)
- i_clk  in  1  clock, all state on rising edge
- i_resetn  in  1  reset, asynchronous, active-low
- i_mem_mem2reg  in  1  load request from EXE/MEM register
- i_mem_wmem  in  1  store request from EXE/MEM register
- i_mem_lsb, i_mem_lsh  in  1 each  byte / halfword size (neither = word)
- i_mem_loadsignext  in  1  sign-extend sub-word load (else zero-extend)
- i_mem_addr  in  32  byte address
- i_mem_wdata  in  32  store data, right-aligned
- data_req_o  out  1  bus request
- data_addr_o  out  32  word-aligned address ({i_mem_addr[31:2],2'b00})
- data_we_o  out  1  1 = store
- data_be_o  out  4  byte enables
- data_wdata_o  out  32  lane-replicated store data
- data_gnt_i  in  1  grant
- data_rvalid_i  in  1  response valid, loads and stores
- data_rdata_i  in  32  read data
- o_stall  out  1  hold IF..EXE/MEM registers this cycle
- o_load_valid  out  1  load result valid this cycle
- o_load_data  out  32  aligned, extended load result
- o_misaligned  out  1  one-cycle pulse, access dropped
- o_bus_err  out  1  sticky timeout flag
- o_stop_core  out  1  sticky core-stop flag

## Operation
- Access present: acc = i_mem_mem2reg | i_mem_wmem. If both are set, the access is a load.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0. This pulses o_misaligned for that cycle, issues no bus request, and asserts no stall.
- Halt store: wmem & HALT_LO < addr < HALT_HI (both bounds strict) & wdata != 0.
  - No bus request is issued.
  - o_stop_core is set at the next edge. FSM goes to HALT.
  - A halt-window store with wdata == 0 is a normal bus store.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
- Write data: byte replicated ×4; half replicated ×2; word unchanged.
- Load data: select lane by addr[1:0] (byte) or addr[1] (half). Sign- or zero-extend per i_mem_loadsignext.
- FSM states: IDLE, REQ, WAIT, HALT.
  - IDLE: data_req_o = acc & aligned & !halt-store. gnt → WAIT, else → REQ.
  - REQ: data_req_o = 1. gnt → WAIT.
  - WAIT: data_req_o = 0. rvalid → IDLE (completion).
  - HALT: terminal until reset. data_req_o = 0, o_stall = 1.
- o_stall = 1 in IDLE while a bus access is requested, in REQ, in WAIT without rvalid, and in HALT. It is 0 otherwise, including the completion cycle.
- o_load_valid = WAIT & rvalid & load, combinational. o_load_data is valid only then; otherwise it is 0.
- Timeout counter:
  - Clears on entry to REQ/WAIT from IDLE and increments each REQ/WAIT cycle.
  - Reaching TIMEOUT sets o_bus_err and o_stop_core and goes to HALT.
  - An rvalid in that same cycle still completes the access, but HALT wins.
- The access type (load/store, size, address) is latched on grant. The bus and pipeline fields are held stable by o_stall.

## Timing
- Reset values: state IDLE, counter 0. All outputs 0, except o_stall, which follows acc combinationally in IDLE.
- Best-case access: gnt in the IDLE cycle and rvalid in the next cycle. That is 2 cycles total, of which 1 is a stall cycle.
- Each extra cycle without gnt or rvalid adds 1 stall cycle.
- A back-to-back access is presented in the cycle after completion, in IDLE. There is no bubble.
- gnt and rvalid in the same cycle in IDLE/REQ: rvalid is ignored; only gnt is honoured.
- Reset asserted mid-access: the block returns to IDLE immediately and data_req_o drops asynchronously. Sticky flags clear.
- o_stop_core and o_bus_err rise at the edge after detection and hold until reset.

## Test plan
- Word load, addr 0x100, gnt same cycle, rvalid next with rdata 0xDEADBEEF → o_stall=1 for 1 cycle; o_load_valid=1, o_load_data=0xDEADBEEF.
- Byte load, signext, addr 0x103, rdata 0x80112233 → be=4'b1000, o_load_data=0xFFFFFF80. With zero-extend → 0x00000080.
- Halfword store, addr 0x202, wdata 0x0000ABCD, gnt delayed 3 cycles → data_be_o=4'b1100, data_wdata_o=0xABCDABCD, 4 stall cycles before rvalid plus completion.
- Store addr 0x20010, wdata 1 → no data_req_o, o_stop_core=1 next cycle, o_stall stays 1. Same store with wdata 0 → normal bus store. Address exactly 0x20000 → normal bus store.
- Word load addr 0x101 → o_misaligned pulse, data_req_o=0, o_stall=0.
- gnt given, rvalid withheld with TIMEOUT=4 → o_bus_err=1 and o_stop_core=1 after 4 REQ/WAIT cycles. Then assert reset mid-HALT → all flags 0, state IDLE.
